// File: rtl/iob_bus_pkg.sv
// Shared definitions for the packed native bus: widths, field offsets and
// the merge-block state encoding.
package iob_bus_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } state_e;

   function automatic int unsigned strb_w(input int unsigned data_w);
      return data_w / 8;
   endfunction

   function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int unsigned resp_w(input int unsigned data_w);
      return data_w + 1;
   endfunction

   // Request is {valid, addr, wdata, wstrb} with wstrb in the LSBs.
   function automatic int unsigned valid_off(input int unsigned addr_w,
                                             input int unsigned data_w);
      return addr_w + data_w + data_w / 8;
   endfunction

   function automatic int unsigned addr_off(input int unsigned data_w);
      return data_w + data_w / 8;
   endfunction

   function automatic int unsigned wdata_off(input int unsigned data_w);
      return data_w / 8;
   endfunction

   localparam int unsigned WstrbOff = 0;

   // Response is {rdata, ready}.
   localparam int unsigned ReadyOff = 0;
   localparam int unsigned RdataOff = 1;

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-way round-robin pick; on a tie the master not granted last time wins.
module iob_rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o,
   output logic       grant_idx_o
);

   always_comb begin
      grant_idx_o = 1'b0;
      case (req_i)
         2'b01:   grant_idx_o = 1'b0;
         2'b10:   grant_idx_o = 1'b1;
         2'b11:   grant_idx_o = ~last_grant_i;
         default: grant_idx_o = 1'b0;
      endcase
      grant_o = 2'b00;
      if (|req_i) grant_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/iob_vexriscv_bus_merge.sv
// Merges the VexRiscv dbus (m0) and ibus (m1) onto one native port with a
// registered request and one outstanding transaction.
module iob_vexriscv_bus_merge
   import iob_bus_pkg::*;
#(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned REQ_W  = req_w(ADDR_W, DATA_W),
   localparam int unsigned RESP_W = resp_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ REQ_W-1:0] m0_req,
   output logic [RESP_W-1:0] m0_resp,
   input  logic [ REQ_W-1:0] m1_req,
   output logic [RESP_W-1:0] m1_resp,
   output logic [ REQ_W-1:0] s_req,
   input  logic [RESP_W-1:0] s_resp,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned STRB_W   = strb_w(DATA_W);
   localparam int unsigned VALID_O  = valid_off(ADDR_W, DATA_W);
   localparam int unsigned ADDR_O   = addr_off(DATA_W);
   localparam int unsigned WDATA_O  = wdata_off(DATA_W);

   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;

   logic [1:0]          arb_req;
   logic [1:0]          arb_grant;
   logic                arb_idx;
   logic [REQ_W-1:0]    win_req;
   logic                s_ready;

   // Requests are only arbitrated while idle, so a completing master that
   // still holds valid is never reissued.
   assign arb_req = (state_q == StIdle) ? {m1_req[VALID_O], m0_req[VALID_O]} : 2'b00;
   assign win_req = arb_idx ? m1_req : m0_req;
   assign s_ready = s_resp[ReadyOff];

   iob_rr_arb2 u_arb (
      .req_i        (arb_req),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .grant_idx_o  (arb_idx)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      case (state_q)
         StIdle: begin
            if (|arb_grant) begin
               addr_d       = win_req[ADDR_O +: ADDR_W];
               wdata_d      = win_req[WDATA_O +: DATA_W];
               wstrb_d      = win_req[WstrbOff +: STRB_W];
               valid_d      = 1'b1;
               owner_d      = arb_idx;
               last_grant_d = arb_idx;
               state_d      = StBusy;
            end
         end
         StBusy: begin
            if (s_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         valid_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Spurious slave responses while idle are dropped by gating on busy.
   always_comb begin
      busy    = (state_q == StBusy);
      owner   = owner_q;
      s_req   = busy ? {valid_q, addr_q, wdata_q, wstrb_q} : '0;
      m0_resp = (busy && !owner_q) ? s_resp : '0;
      m1_resp = (busy && owner_q) ? s_resp : '0;
   end

endmodule

// File: tb/tb_iob_vexriscv_bus_merge.sv
// Directed cycle-by-cycle bench for the dbus/ibus merge block.
module tb_iob_vexriscv_bus_merge;
   import iob_bus_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REQ_W  = req_w(ADDR_W, DATA_W);
   localparam int unsigned RESP_W = resp_w(DATA_W);

   typedef struct {
      logic              rst;
      logic [REQ_W-1:0]  m0;
      logic [REQ_W-1:0]  m1;
      logic [RESP_W-1:0] s;
      logic [REQ_W-1:0]  es;
      logic [RESP_W-1:0] em0;
      logic [RESP_W-1:0] em1;
      logic              eb;
      logic              eo;
   } vec_t;

   logic              clk;
   logic              rst;
   logic [REQ_W-1:0]  m0_req, m1_req, s_req;
   logic [RESP_W-1:0] m0_resp, m1_resp, s_resp;
   logic              busy, owner;

   int errors = 0;
   int checks = 0;
   int step_no = 0;

   iob_vexriscv_bus_merge #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .m0_req  (m0_req),
      .m0_resp (m0_resp),
      .m1_req  (m1_req),
      .m1_resp (m1_resp),
      .s_req   (s_req),
      .s_resp  (s_resp),
      .busy    (busy),
      .owner   (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [31:0] a,
                                                 input logic [31:0] d, input logic [3:0] s);
      return {v, a, d, s};
   endfunction

   function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] d, input logic r);
      return {d, r};
   endfunction

   function automatic vec_t mkv(input logic r, input logic [REQ_W-1:0] m0,
                                input logic [REQ_W-1:0] m1, input logic [RESP_W-1:0] s,
                                input logic [REQ_W-1:0] es, input logic [RESP_W-1:0] em0,
                                input logic [RESP_W-1:0] em1, input logic eb, input logic eo);
      vec_t v;
      v.rst = r; v.m0 = m0; v.m1 = m1; v.s = s;
      v.es = es; v.em0 = em0; v.em1 = em1; v.eb = eb; v.eo = eo;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, compare on the falling edge.
   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      rst    = v.rst;
      m0_req = v.m0;
      m1_req = v.m1;
      s_resp = v.s;
      @(negedge clk);
      chk("s_req", 128'(s_req), 128'(v.es));
      chk("m0_resp", 128'(m0_resp), 128'(v.em0));
      chk("m1_resp", 128'(m1_resp), 128'(v.em1));
      chk("busy", 128'(busy), 128'(v.eb));
      if (v.eb) chk("owner", 128'(owner), 128'(v.eo));
      step_no++;
   endtask

   vec_t tbl[15];
   logic [REQ_W-1:0]  z, m0a, t0, t1, t2, t3, rq;
   logic [RESP_W-1:0] zr;

   initial begin
      z   = '0;
      zr  = '0;
      m0a = mk_req(1'b1, 32'h100, 32'h0, 4'h0);
      t0  = mk_req(1'b1, 32'h200, 32'h12345678, 4'hF);
      t1  = mk_req(1'b1, 32'h0, 32'h0, 4'h0);
      t2  = mk_req(1'b1, 32'h300, 32'h0, 4'h0);
      t3  = mk_req(1'b1, 32'h4, 32'h0, 4'h0);

      // Single dbus read, slave answers two cycles after s valid.
      tbl[0]  = mkv(0, m0a, z, zr, z, zr, zr, 0, 0);
      tbl[1]  = mkv(0, m0a, z, zr, m0a, zr, zr, 1, 0);
      tbl[2]  = mkv(0, m0a, z, zr, m0a, zr, zr, 1, 0);
      tbl[3]  = mkv(0, m0a, z, mk_resp(32'hDEADBEEF, 1), m0a,
                    mk_resp(32'hDEADBEEF, 1), zr, 1, 0);
      tbl[4]  = mkv(0, z, z, zr, z, zr, zr, 0, 0);
      // Ties after reset alternate m0, m1, m0.
      tbl[5]  = mkv(1, z, z, zr, z, zr, zr, 0, 0);
      tbl[6]  = mkv(0, t0, t1, zr, z, zr, zr, 0, 0);
      tbl[7]  = mkv(0, t0, t1, mk_resp(32'h0, 1), t0, mk_resp(32'h0, 1), zr, 1, 0);
      tbl[8]  = mkv(0, t2, t1, zr, z, zr, zr, 0, 0);
      tbl[9]  = mkv(0, t2, t1, mk_resp(32'hA5A5A5A5, 1), t1, zr,
                    mk_resp(32'hA5A5A5A5, 1), 1, 1);
      tbl[10] = mkv(0, t2, t3, zr, z, zr, zr, 0, 0);
      tbl[11] = mkv(0, t2, t3, mk_resp(32'h11, 1), t2, mk_resp(32'h11, 1), zr, 1, 0);
      tbl[12] = mkv(0, z, z, zr, z, zr, zr, 0, 0);
      // Spurious slave ready while idle.
      tbl[13] = mkv(0, z, z, mk_resp(32'hFFFFFFFF, 1), z, zr, zr, 0, 0);
      tbl[14] = mkv(0, z, z, zr, z, zr, zr, 0, 0);

      rst    = 1'b1;
      m0_req = '0;
      m1_req = '0;
      s_resp = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_s_req", 128'(s_req), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_owner", 128'(owner), 128'(0));

      for (int i = 0; i < 15; i++) step(tbl[i]);

      // Back-to-back ibus reads with same-cycle slave answers.
      for (int i = 0; i < 4; i++) begin
         rq = mk_req(1'b1, 32'(i * 4), 32'h0, 4'h0);
         step(mkv(0, z, rq, zr, z, zr, zr, 0, 0));
         step(mkv(0, z, rq, mk_resp(32'(32'h1000 + i), 1), rq, zr,
                  mk_resp(32'(32'h1000 + i), 1), 1, 1));
      end

      // Owner drops valid while busy; the captured request still completes.
      rq = mk_req(1'b1, 32'h400, 32'h55, 4'h3);
      step(mkv(0, rq, z, zr, z, zr, zr, 0, 0));
      step(mkv(0, z, z, zr, rq, zr, zr, 1, 0));
      step(mkv(0, z, z, mk_resp(32'h77, 1), rq, mk_resp(32'h77, 1), zr, 1, 0));
      step(mkv(0, z, z, zr, z, zr, zr, 0, 0));

      // Reset while busy aborts; the late slave ready is ignored.
      rq = mk_req(1'b1, 32'h500, 32'h0, 4'h0);
      step(mkv(0, z, rq, zr, z, zr, zr, 0, 0));
      step(mkv(1, z, rq, zr, rq, zr, zr, 1, 1));
      step(mkv(0, z, z, mk_resp(32'h99, 1), z, zr, zr, 0, 0));
      rq = mk_req(1'b1, 32'h504, 32'h0, 4'h0);
      step(mkv(0, z, rq, zr, z, zr, zr, 0, 0));
      step(mkv(0, z, rq, mk_resp(32'hCAFE, 1), rq, zr, mk_resp(32'hCAFE, 1), 1, 1));
      step(mkv(0, z, z, zr, z, zr, zr, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
